// File: rtl/parity_engine_pkg.sv
// Shared types and constants for the bit-serial parity engine.
package parity_pkg;

   localparam int unsigned MIN_LEN = 5;
   localparam int unsigned MODE_W  = 3;

   typedef enum logic [MODE_W-1:0] {
      P_NONE  = 3'd0,
      P_EVEN  = 3'd1,
      P_ODD   = 3'd2,
      P_MARK  = 3'd3,
      P_SPACE = 3'd4
   } p_mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Encodings above P_SPACE are reserved and rejected at start.
   function automatic logic mode_legal(input logic [MODE_W-1:0] m);
      return m <= MODE_W'(P_SPACE);
   endfunction

endpackage

// File: rtl/parity_engine_if.sv
// Frame-controller <-> parity engine handshake and result bundle.
interface parity_engine_if
   import parity_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
);

   logic              start;
   logic [DATA_W-1:0] data;
   logic [LEN_W-1:0]  data_len;
   logic [MODE_W-1:0] p_mode;
   logic              chk_en;
   logic              chk_bit;
   logic              busy;
   logic              p_valid;
   logic              p_bit;
   logic              p_en;
   logic              p_err;
   logic              cfg_err;

   modport master (
      output start, data, data_len, p_mode, chk_en, chk_bit,
      input  busy, p_valid, p_bit, p_en, p_err, cfg_err
   );

   modport slave (
      input  start, data, data_len, p_mode, chk_en, chk_bit,
      output busy, p_valid, p_bit, p_en, p_err, cfg_err
   );

endinterface

// File: rtl/parity_engine_map.sv
// Mode/accumulator to parity-bit mapping; shared with the Rx checker.
module parity_map
   import parity_pkg::*;
(
   input  p_mode_t mode_i,
   input  logic    acc_i,
   output logic    p_bit_c_o,
   output logic    p_en_c_o
);

   always_comb begin
      p_bit_c_o = 1'b0;
      p_en_c_o  = 1'b0;
      case (mode_i)
         P_EVEN: begin
            p_bit_c_o = acc_i;
            p_en_c_o  = 1'b1;
         end
         P_ODD: begin
            p_bit_c_o = ~acc_i;
            p_en_c_o  = 1'b1;
         end
         P_MARK: begin
            p_bit_c_o = 1'b1;
            p_en_c_o  = 1'b1;
         end
         P_SPACE: begin
            p_bit_c_o = 1'b0;
            p_en_c_o  = 1'b1;
         end
         default: begin
            p_bit_c_o = 1'b0;
            p_en_c_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/parity_engine.sv
// Bit-serial parity generator/checker: latches a frame, folds data_len
// bits LSB first into an accumulator, then reports parity for one cycle.
module parity_engine
   import parity_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
   input  logic            clk,
   input  logic            reset,
   parity_engine_if.slave  bus
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              acc_q, acc_d;
   p_mode_t           mode_q, mode_d;
   logic              chk_en_q, chk_en_d;
   logic              chk_bit_q, chk_bit_d;

   logic busy_q, busy_d;
   logic p_valid_q, p_valid_d;
   logic p_bit_q, p_bit_d;
   logic p_en_q, p_en_d;
   logic p_err_q, p_err_d;
   logic cfg_err_q, cfg_err_d;

   logic    cfg_ok_c;
   p_mode_t map_mode_c;
   logic    map_acc_c;
   logic    map_bit_c;
   logic    map_en_c;

   assign cfg_ok_c = (bus.data_len >= LEN_W'(MIN_LEN)) &&
                     (bus.data_len <= LEN_W'(DATA_W)) &&
                     mode_legal(bus.p_mode);

   // DONE is entered either from IDLE (NONE only, result is 0/0 regardless of
   // acc) or from the last SHIFT cycle, so map the incoming result directly.
   assign map_mode_c = (state_q == IDLE) ? p_mode_t'(bus.p_mode) : mode_q;
   assign map_acc_c  = acc_q ^ shreg_q[0];

   parity_map u_map (
      .mode_i    (map_mode_c),
      .acc_i     (map_acc_c),
      .p_bit_c_o (map_bit_c),
      .p_en_c_o  (map_en_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         cnt_q     <= '0;
         acc_q     <= 1'b0;
         mode_q    <= P_NONE;
         chk_en_q  <= 1'b0;
         chk_bit_q <= 1'b0;
         busy_q    <= 1'b0;
         p_valid_q <= 1'b0;
         p_bit_q   <= 1'b0;
         p_en_q    <= 1'b0;
         p_err_q   <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mode_q    <= mode_d;
         chk_en_q  <= chk_en_d;
         chk_bit_q <= chk_bit_d;
         busy_q    <= busy_d;
         p_valid_q <= p_valid_d;
         p_bit_q   <= p_bit_d;
         p_en_q    <= p_en_d;
         p_err_q   <= p_err_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mode_d    = mode_q;
      chk_en_d  = chk_en_q;
      chk_bit_d = chk_bit_q;
      p_valid_d = 1'b0;
      p_bit_d   = p_bit_q;
      p_en_d    = p_en_q;
      p_err_d   = 1'b0;
      cfg_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (cfg_ok_c) begin
                  shreg_d   = bus.data;
                  cnt_d     = bus.data_len;
                  acc_d     = 1'b0;
                  mode_d    = p_mode_t'(bus.p_mode);
                  chk_en_d  = bus.chk_en;
                  chk_bit_d = bus.chk_bit;
                  state_d   = (p_mode_t'(bus.p_mode) == P_NONE) ? DONE : SHIFT;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         SHIFT: begin
            acc_d   = map_acc_c;
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);

      // Result registers load on DONE entry so they are valid with p_valid.
      if (state_d == DONE) begin
         p_valid_d = 1'b1;
         p_bit_d   = map_bit_c;
         p_en_d    = map_en_c;
         p_err_d   = chk_en_d & map_en_c & (chk_bit_d != map_bit_c);
      end
   end

   assign bus.busy    = busy_q;
   assign bus.p_valid = p_valid_q;
   assign bus.p_bit   = p_bit_q;
   assign bus.p_en    = p_en_q;
   assign bus.p_err   = p_err_q;
   assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_parity_engine.sv
// Scoreboard bench for parity_engine: expected results queued at start,
// popped and compared when p_valid appears.
module tb_parity_engine;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned LEN_W  = $clog2(DATA_W + 1);

   typedef struct {
      logic p_bit;
      logic p_en;
      logic p_err;
      int   due;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   vcnt = 0;
   exp_t sb[$];
   exp_t mon_e;
   exp_t last_e;

   parity_engine_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

   parity_engine #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [7:0] d, input int len, input int mode,
                                  input logic ce, input logic cb, input int t);
      exp_t e;
      logic par;
      par = 1'b0;
      for (int i = 0; i < len; i++) par = par ^ d[i];
      case (mode)
         1: begin e.p_bit = par;  e.p_en = 1'b1; end
         2: begin e.p_bit = ~par; e.p_en = 1'b1; end
         3: begin e.p_bit = 1'b1; e.p_en = 1'b1; end
         4: begin e.p_bit = 1'b0; e.p_en = 1'b1; end
         default: begin e.p_bit = 1'b0; e.p_en = 1'b0; end
      endcase
      e.p_err = ce & e.p_en & (cb != e.p_bit);
      e.due   = (mode == 0) ? t : t + len;
      return e;
   endfunction

   // Result monitor.
   always @(negedge clk) begin
      if (bus.p_valid === 1'b1) begin
         vcnt++;
         if (sb.size() == 0) begin
            check_eq("spurious_p_valid", int'(bus.p_valid), 0);
         end else begin
            mon_e = sb.pop_front();
            check_eq("p_bit", int'(bus.p_bit), int'(mon_e.p_bit));
            check_eq("p_en", int'(bus.p_en), int'(mon_e.p_en));
            check_eq("p_err", int'(bus.p_err), int'(mon_e.p_err));
            check_eq("latency", cyc, mon_e.due);
         end
      end
   end

   task automatic drive(input logic [7:0] d, input int len, input int mode,
                        input logic ce, input logic cb);
      bus.start    = 1'b1;
      bus.data     = d;
      bus.data_len = LEN_W'(len);
      bus.p_mode   = 3'(mode);
      bus.chk_en   = ce;
      bus.chk_bit  = cb;
   endtask

   task automatic scramble();
      bus.start    = 1'b0;
      bus.data     = 8'($urandom);
      bus.data_len = LEN_W'($urandom_range(0, 15));
      bus.p_mode   = 3'($urandom_range(0, 7));
      bus.chk_en   = 1'($urandom);
      bus.chk_bit  = 1'($urandom);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check_eq("timeout_pending", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic run_frame(input logic [7:0] d, input int len, input int mode,
                            input logic ce, input logic cb);
      int   t;
      logic legal;
      @(negedge clk);
      legal = (len >= 5) && (len <= 8) && (mode <= 4);
      drive(d, len, mode, ce, cb);
      t = cyc + 1;
      if (legal) begin
         last_e = model(d, len, mode, ce, cb, t);
         sb.push_back(last_e);
      end
      @(negedge clk);
      scramble();
      if (legal) begin
         check_eq("busy_after_start", int'(bus.busy), 1);
         check_eq("no_cfg_err", int'(bus.cfg_err), 0);
         wait_drain();
         @(negedge clk);
         check_eq("busy_back_idle", int'(bus.busy), 0);
         check_eq("p_bit_hold", int'(bus.p_bit), int'(last_e.p_bit));
         check_eq("p_en_hold", int'(bus.p_en), int'(last_e.p_en));
         check_eq("p_err_drop", int'(bus.p_err), 0);
      end else begin
         check_eq("cfg_err_pulse", int'(bus.cfg_err), 1);
         check_eq("busy_rejected", int'(bus.busy), 0);
         @(negedge clk);
         check_eq("cfg_err_one_cycle", int'(bus.cfg_err), 0);
         check_eq("busy_still_idle", int'(bus.busy), 0);
         check_eq("no_valid_rejected", int'(bus.p_valid), 0);
      end
   endtask

   initial begin
      int v0;
      reset = 1'b1;
      scramble();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_eq("rst_busy", int'(bus.busy), 0);
      check_eq("rst_p_valid", int'(bus.p_valid), 0);
      check_eq("rst_p_bit", int'(bus.p_bit), 0);
      check_eq("rst_p_en", int'(bus.p_en), 0);
      check_eq("rst_p_err", int'(bus.p_err), 0);
      check_eq("rst_cfg_err", int'(bus.cfg_err), 0);

      // Directed frames.
      run_frame(8'hA5, 8, 1, 1'b0, 1'b0);
      run_frame(8'hA5, 8, 2, 1'b0, 1'b0);
      run_frame(8'hFF, 7, 1, 1'b0, 1'b0);
      run_frame(8'h3C, 5, 3, 1'b0, 1'b0);
      run_frame(8'h3C, 5, 4, 1'b0, 1'b0);
      run_frame(8'h5A, 8, 0, 1'b1, 1'b1);
      run_frame(8'h01, 8, 1, 1'b1, 1'b0);
      run_frame(8'h01, 8, 1, 1'b1, 1'b1);
      run_frame(8'h1F, 5, 2, 1'b1, 1'b1);

      // Rejected configurations.
      run_frame(8'hA5, 4, 1, 1'b0, 1'b0);
      run_frame(8'hA5, 8, 6, 1'b0, 1'b0);
      run_frame(8'hA5, 9, 1, 1'b0, 1'b0);

      // Start while busy is dropped, not queued.
      v0 = vcnt;
      @(negedge clk);
      drive(8'hA5, 8, 1, 1'b0, 1'b0);
      last_e = model(8'hA5, 8, 1, 1'b0, 1'b0, cyc + 1);
      sb.push_back(last_e);
      @(negedge clk);
      scramble();
      repeat (2) @(negedge clk);
      drive(8'h00, 5, 3, 1'b0, 1'b0);
      @(negedge clk);
      scramble();
      wait_drain();
      repeat (10) @(negedge clk);
      check_eq("busy_start_dropped", vcnt - v0, 1);
      check_eq("idle_after_drop", int'(bus.busy), 0);

      // Set p_bit=1 so a later reset visibly clears it.
      run_frame(8'hA5, 8, 2, 1'b0, 1'b0);

      // Reset in the middle of SHIFT aborts the frame.
      @(negedge clk);
      drive(8'hFF, 8, 1, 1'b0, 1'b0);
      sb.push_back(model(8'hFF, 8, 1, 1'b0, 1'b0, cyc + 1));
      @(negedge clk);
      scramble();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      check_eq("abort_busy", int'(bus.busy), 0);
      check_eq("abort_p_bit", int'(bus.p_bit), 0);
      check_eq("abort_p_en", int'(bus.p_en), 0);
      check_eq("abort_p_valid", int'(bus.p_valid), 0);
      v0 = vcnt;
      repeat (12) @(negedge clk);
      check_eq("abort_no_valid", vcnt - v0, 0);
      run_frame(8'h07, 6, 1, 1'b1, 1'b0);

      // Random legal frames.
      for (int k = 0; k < 16; k++) begin
         run_frame(8'($urandom), int'($urandom_range(5, 8)), int'($urandom_range(0, 4)),
                   1'($urandom), 1'($urandom));
      end

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
